// File: rtl/pq_access_arbiter.sv
// rtl/pq_access_arbiter.sv - round-robin arbiter sharing one register-tree priority queue
// Optional saturating error counter on o_err_count: define PQ_ARB_ERR_COUNT_EN.
module pq_access_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 2,
  localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [2*NUM_REQ-1:0]          i_req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_rsp_valid,
  output logic [ID_W-1:0]               o_rsp_id,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_rsp_err,
  output logic                          o_pq_wrt,
  output logic                          o_pq_read,
  output logic [DATA_WIDTH-1:0]         o_pq_data,
  input  logic                          i_pq_full,
  input  logic                          i_pq_empty,
  input  logic [DATA_WIDTH-1:0]         i_pq_data,
  output logic [7:0]                    o_err_count
);

  localparam int CW    = ID_W + 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_SETTLE = 2'd2} state_t;

  state_t                state_q;
  logic [ID_W-1:0]       rr_ptr_q;
  logic [ID_W-1:0]       id_q;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  rsp_valid_q;
  logic [ID_W-1:0]       rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;

  logic                  grant_found;
  logic [ID_W-1:0]       grant_id;
  logic [CW-1:0]         cand;
  logic                  legal;
  logic                  issue_ok;

  // Search starts just above the last winner so every requester is served within NUM_REQ grants.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!grant_found && i_req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (RSTn && state_q == ST_IDLE && grant_found) o_req_ready = NUM_REQ'(1) << grant_id;
  end

  always_comb begin
    legal = 1'b0;
    case (op_q)
      2'b01:        legal = !i_pq_full;
      2'b10, 2'b11: legal = !i_pq_empty;
      default:      legal = 1'b0;
    endcase
  end

  assign issue_ok  = (state_q == ST_ISSUE) && legal;
  assign o_pq_wrt  = issue_ok && op_q[0];
  assign o_pq_read = issue_ok && op_q[1];
  assign o_pq_data = issue_ok ? data_q : '0;

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      op_q        <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_found) begin
            id_q     <= grant_id;
            op_q     <= i_req_op[2*grant_id +: 2];
            data_q   <= i_req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
            rr_ptr_q <= grant_id;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= id_q;
          rsp_err_q   <= !legal;
          // Queue top is captured in the strobe cycle, before the CAS network reorders it.
          if (legal && op_q[1]) rsp_data_q <= i_pq_data;
          if (legal) begin
            cnt_q   <= CNT_W'(SETTLE_CYCLES - 1);
            state_q <= ST_SETTLE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PQ_ARB_ERR_COUNT_EN
  logic [7:0] err_cnt_q;
  logic [7:0] err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_q == ST_ISSUE && !legal && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) err_cnt_q <= 8'd0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign o_err_count = err_cnt_q;
`else
  assign o_err_count = 8'd0;
`endif

endmodule

// File: tb/tb_pq_access_arbiter.sv
// tb/tb_pq_access_arbiter.sv - directed bench for pq_access_arbiter
// Expected error counts follow PQ_ARB_ERR_COUNT_EN when the bench is built with it.
module tb_pq_access_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
`ifdef PQ_ARB_ERR_COUNT_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic            CLK = 1'b0;
  logic            RSTn;
  logic [N-1:0]    i_req_valid;
  logic [2*N-1:0]  i_req_op;
  logic [N*DW-1:0] i_req_data;
  logic [N-1:0]    o_req_ready;
  logic            o_rsp_valid;
  logic [1:0]      o_rsp_id;
  logic [DW-1:0]   o_rsp_data;
  logic            o_rsp_err;
  logic            o_pq_wrt;
  logic            o_pq_read;
  logic [DW-1:0]   o_pq_data;
  logic            i_pq_full;
  logic            i_pq_empty;
  logic [DW-1:0]   i_pq_data;
  logic [7:0]      o_err_count;

  int n_tests = 0;
  int n_fail  = 0;

  pq_access_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .SETTLE_CYCLES(2)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .i_req_valid(i_req_valid), .i_req_op(i_req_op), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready),
    .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_pq_wrt(o_pq_wrt), .o_pq_read(o_pq_read), .o_pq_data(o_pq_data),
    .i_pq_full(i_pq_full), .i_pq_empty(i_pq_empty), .i_pq_data(i_pq_data),
    .o_err_count(o_err_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [DW-1:0] d);
    i_req_valid[r]        = 1'b1;
    i_req_op[2*r +: 2]    = op;
    i_req_data[r*DW +: DW] = d;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                         input logic [DW-1:0] d, input logic e);
    chk({tag, "_rsp_valid"}, o_rsp_valid, v);
    chk({tag, "_rsp_id"},    o_rsp_id,    id);
    chk({tag, "_rsp_data"},  o_rsp_data,  d);
    chk({tag, "_rsp_err"},   o_rsp_err,   e);
  endtask

  initial begin
    RSTn = 1'b0; i_req_valid = '0; i_req_op = '0; i_req_data = '0;
    i_pq_full = 1'b0; i_pq_empty = 1'b1; i_pq_data = '0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_ready", o_req_ready, 0);
    chk_rsp("rst", 1'b0, 2'd0, 16'h0, 1'b0);
    chk("rst_wrt", o_pq_wrt, 0);
    chk("rst_read", o_pq_read, 0);
    chk("rst_pq_data", o_pq_data, 0);
    chk("rst_err_count", o_err_count, 0);
    @(negedge CLK) RSTn = 1'b1;

    // push by requester 2, then settle gap before requester 3
    @(negedge CLK); set_req(2, 2'b01, 16'h0010); #1;
    chk("t1_ready_T", o_req_ready, 4'b0100);
    @(negedge CLK); i_req_valid = '0; #1;
    chk("t1_wrt", o_pq_wrt, 1); chk("t1_read", o_pq_read, 0);
    chk("t1_pq_data", o_pq_data, 16'h0010); chk("t1_ready_T1", o_req_ready, 0);
    @(negedge CLK); set_req(3, 2'b01, 16'h0020); #1;
    chk_rsp("t1", 1'b1, 2'd2, 16'h0, 1'b0);
    chk("t1_wrt_T2", o_pq_wrt, 0); chk("t1_ready_T2", o_req_ready, 0);
    @(negedge CLK); #1 chk("t1_ready_T3", o_req_ready, 0);
    @(negedge CLK); #1 chk("t1_ready_T4", o_req_ready, 4'b1000);
    @(negedge CLK); i_req_valid = '0; #1;
    chk("t1b_wrt", o_pq_wrt, 1); chk("t1b_pq_data", o_pq_data, 16'h0020);
    repeat (3) @(negedge CLK);

    // pop by requester 1, top 0x0005 captured at issue
    i_pq_empty = 1'b0; i_pq_data = 16'h0005; set_req(1, 2'b10, 16'h0); #1;
    chk("t2_ready", o_req_ready, 4'b0010);
    @(negedge CLK); i_req_valid = '0; #1;
    chk("t2_read", o_pq_read, 1); chk("t2_wrt", o_pq_wrt, 0);
    @(negedge CLK); i_pq_data = 16'h0010; #1;
    chk_rsp("t2", 1'b1, 2'd1, 16'h0005, 1'b0);
    repeat (2) @(negedge CLK);

    // all four requesters push continuously after reset
    RSTn = 1'b0;
    @(negedge CLK) RSTn = 1'b1;
    @(negedge CLK);
    for (int r = 0; r < N; r++) set_req(r, 2'b01, 16'h0100 + 16'(r));
    for (int k = 0; k <= 16; k++) begin
      if (k != 0) @(negedge CLK);
      #1;
      chk($sformatf("t3_ready_%0d", k), o_req_ready,
          (k % 4 == 0) ? (32'd1 << ((k / 4) % 4)) : 32'd0);
      if (k % 4 == 1) chk($sformatf("t3_pq_data_%0d", k), o_pq_data, 16'h0100 + 16'((k / 4) % 4));
    end
    @(negedge CLK); i_req_valid = '0; #1;
    chk("t3_last_pq_data", o_pq_data, 16'h0100);
    repeat (3) @(negedge CLK);

    // pop on empty queue, then illegal op 00
    i_pq_empty = 1'b1; set_req(1, 2'b10, 16'h0); #1;
    chk("t4_ready", o_req_ready, 4'b0010); chk("t4_errcnt0", o_err_count, 0);
    @(negedge CLK); i_req_valid = '0; #1;
    chk("t4_read", o_pq_read, 0); chk("t4_wrt", o_pq_wrt, 0); chk("t4_pq_data", o_pq_data, 0);
    @(negedge CLK); set_req(2, 2'b00, 16'h0055); #1;
    chk_rsp("t4", 1'b1, 2'd1, 16'h0, 1'b1);
    chk("t4_idle_ready", o_req_ready, 4'b0100);
    chk("t4_errcnt1", o_err_count, 32'(ERR_EN));
    @(negedge CLK); i_req_valid = '0; #1;
    chk("t4b_wrt", o_pq_wrt, 0); chk("t4b_read", o_pq_read, 0);
    @(negedge CLK); #1;
    chk_rsp("t4b", 1'b1, 2'd2, 16'h0, 1'b1);
    chk("t4_errcnt2", o_err_count, 32'(2 * ERR_EN));

    // replace by requester 3
    @(negedge CLK); i_pq_empty = 1'b0; i_pq_data = 16'h0007; set_req(3, 2'b11, 16'h0003); #1;
    chk("t5_ready", o_req_ready, 4'b1000);
    @(negedge CLK); i_req_valid = '0; #1;
    chk("t5_wrt", o_pq_wrt, 1); chk("t5_read", o_pq_read, 1); chk("t5_pq_data", o_pq_data, 16'h0003);
    @(negedge CLK); i_pq_data = 16'h0009; #1;
    chk_rsp("t5", 1'b1, 2'd3, 16'h0007, 1'b0);
    repeat (2) @(negedge CLK);

    // reset asserted while the push settles
    set_req(0, 2'b01, 16'h0042); #1;
    chk("t6_ready", o_req_ready, 4'b0001);
    @(negedge CLK); i_req_valid = '0; #1;
    chk("t6_wrt", o_pq_wrt, 1);
    @(negedge CLK); set_req(0, 2'b01, 16'h0011); set_req(3, 2'b01, 16'h0033); RSTn = 1'b0; #1;
    chk_rsp("t6_rst", 1'b0, 2'd0, 16'h0, 1'b0);
    chk("t6_rst_ready", o_req_ready, 0); chk("t6_rst_wrt", o_pq_wrt, 0);
    chk("t6_rst_errcnt", o_err_count, 0);
    @(negedge CLK); RSTn = 1'b1; #1;
    chk("t6_ready_after", o_req_ready, 4'b0001);
    @(negedge CLK); i_req_valid = '0; #1;
    chk("t6_wrt_after", o_pq_wrt, 1); chk("t6_pq_data_after", o_pq_data, 16'h0011);
    repeat (3) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
